// File: rtl/fb_pkg.sv
// Shared types and constants for the ping-pong frame buffer controller.
package fb_pkg;

  // Width of the saturating error/drop counters.
  localparam int FB_CNT_W = 8;

  // Writer FSM states.
  typedef enum logic [1:0] {
    FB_IDLE,
    FB_FILL,
    FB_FULL
  } fb_state_e;

endpackage

// File: rtl/fb_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module fb_sat_counter
  import fb_pkg::*;
#(
  parameter int W = FB_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fb_bank_ctrl.sv
// Ping-pong frame buffer controller: ingest fills the back bank of a
// dual-port BRAM while the scanner reads the front bank; banks swap only
// at scanner frame boundaries.
// Optional feature macro FB_OVERRUN_DROP_EN: when defined, beats arriving
// while a full frame waits for the swap are accepted and discarded (and
// start-of-frame beats are counted in drop_cnt) instead of being stalled.
module fb_bank_ctrl
  import fb_pkg::*;
#(
  parameter int FRAME_PIXELS = 4096,
  parameter int RAM_WIDTH    = 24,
  localparam int PIX_W       = $clog2(FRAME_PIXELS)
) (
  input  logic                 clka,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [RAM_WIDTH-1:0] in_data,
  input  logic                 rd_req,
  input  logic [PIX_W-1:0]     rd_addr,
  input  logic                 rd_frame_done,
  output logic                 rd_valid,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic [PIX_W:0]       ram_addra,
  output logic [RAM_WIDTH-1:0] ram_dina,
  output logic                 ram_wea,
  output logic [PIX_W:0]       ram_addrb,
  output logic                 ram_enb,
  input  logic [RAM_WIDTH-1:0] ram_doutb,
  output logic                 front_bank,
  output logic [FB_CNT_W-1:0]  frame_err,
  output logic [FB_CNT_W-1:0]  drop_cnt
);

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

  fb_state_e              state_q, state_d;
  logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic                   front_bank_q, front_bank_d;
  logic                   in_ready_q, in_ready_d;
  logic                   wea_q, wea_d;
  logic [PIX_W:0]         addra_q, addra_d;
  logic [RAM_WIDTH-1:0]   dina_q, dina_d;
  logic                   rd_valid_q;
  logic                   accept;
  logic                   err_inc;

  assign accept = in_valid && in_ready_q;

  // Writer FSM next state plus the registered BRAM write command.
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    front_bank_d = front_bank_q;
    wea_d        = 1'b0;
    addra_d      = addra_q;
    dina_d       = dina_q;
    err_inc      = 1'b0;
    case (state_q)
      FB_IDLE: begin
        // Wait for a start-of-frame; anything else is noise and dropped.
        if (accept && in_sof) begin
          wea_d     = 1'b1;
          addra_d   = {~front_bank_q, PIX_W'(0)};
          dina_d    = in_data;
          pix_cnt_d = PIX_W'(1);
          state_d   = FB_FILL;
        end
      end
      FB_FILL: begin
        if (accept) begin
          wea_d  = 1'b1;
          dina_d = in_data;
          if (in_sof) begin
            // Resync: restart the back-bank frame from pixel 0.
            addra_d   = {~front_bank_q, PIX_W'(0)};
            pix_cnt_d = PIX_W'(1);
            err_inc   = 1'b1;
          end else begin
            addra_d = {~front_bank_q, pix_cnt_q};
            if (pix_cnt_q == LAST_PIX) begin
              state_d = FB_FULL;
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
          end
        end
      end
      FB_FULL: begin
        // Complete frame waits here until the scanner finishes its frame.
        if (rd_frame_done) begin
          front_bank_d = ~front_bank_q;
          pix_cnt_d    = '0;
          state_d      = FB_IDLE;
        end
      end
      default: state_d = FB_IDLE;
    endcase
`ifdef FB_OVERRUN_DROP_EN
    in_ready_d = 1'b1;
`else
    in_ready_d = (state_d != FB_FULL);
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q      <= FB_IDLE;
      pix_cnt_q    <= '0;
      front_bank_q <= 1'b0;
      in_ready_q   <= 1'b0;
      wea_q        <= 1'b0;
      addra_q      <= '0;
      dina_q       <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      front_bank_q <= front_bank_d;
      in_ready_q   <= in_ready_d;
      wea_q        <= wea_d;
      addra_q      <= addra_d;
      dina_q       <= dina_d;
      rd_valid_q   <= rd_req;
    end
  end

  assign in_ready   = in_ready_q;
  assign ram_wea    = wea_q;
  assign ram_addra  = addra_q;
  assign ram_dina   = dina_q;
  assign front_bank = front_bank_q;

  // Read port is a straight pass-through; BRAM supplies the 1-cycle latency.
  assign ram_enb   = rd_req;
  assign ram_addrb = {front_bank_q, rd_addr};
  assign rd_valid  = rd_valid_q;
  assign rd_data   = ram_doutb;

  fb_sat_counter #(.W(FB_CNT_W)) u_frame_err (
    .clk   (clka),
    .rst_n (rst_n),
    .inc   (err_inc),
    .count (frame_err)
  );

`ifdef FB_OVERRUN_DROP_EN
  logic drop_inc;
  assign drop_inc = accept && in_sof && (state_q == FB_FULL);

  fb_sat_counter #(.W(FB_CNT_W)) u_drop_cnt (
    .clk   (clka),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .count (drop_cnt)
  );
`else
  assign drop_cnt = '0;
`endif

endmodule
